eeprom_arbiter: RTL
===================

Name: eeprom_arbiter

Overview:
- Two-requester arbiter that shares the single EEPROM driver operation/write/read interface between master 0 (parameter RAM) and master 1 (calibration/boot loader).
- Round-robin grant, held for one complete EEPROM transaction: operation accept, write burst or read return, then driver idle.
- Sits between the requesters and the EEPROM driver; routes read data only to the granted master.
- A watchdog releases the grant if the driver stalls.

Parameters:
TIMEOUT_CYC, 24'd5_000_000, max cycles from operation accept to completion before forced release
WR_TYPE, 2'd1, operation_type code meaning write; every other code is treated as read

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, asynchronous, active-low
i_mN_eeprom_addr  in  3  master N device address (N=0,1, same set for each line below)
i_mN_operation_addr  in  16  master N byte address
i_mN_operation_type  in  2  master N op type
i_mN_operation_len  in  8  master N byte count
i_mN_operation_valid  in  1  master N op request
o_mN_operation_ready  out  1  master N op accepted when valid&ready
i_mN_write_data  in  8  master N write byte
i_mN_write_sop  in  1  first write byte
i_mN_write_eop  in  1  last write byte
i_mN_write_valid  in  1  write byte valid
o_mN_read_data  out  8  read byte to master N
o_mN_read_valid  out  1  read byte strobe to master N
o_ctrl_eeprom_addr  out  3  to driver
o_ctrl_operation_addr  out  16  to driver
o_ctrl_operation_type  out  2  to driver
o_ctrl_operation_len  out  8  to driver
o_ctrl_operation_valid  out  1  to driver
i_ctrl_operation_ready  in  1  driver idle/accept
o_ctrl_write_data  out  8  to driver
o_ctrl_write_sop  out  1  to driver
o_ctrl_write_eop  out  1  to driver
o_ctrl_write_valid  out  1  to driver
i_ctrl_read_data  in  8  from driver
i_ctrl_read_valid  in  1  from driver
o_grant  out  1  current owner (0/1), valid when o_busy
o_busy  out  1  grant active
o_timeout  out  1  one-cycle pulse on watchdog release

Behaviour:
- Reset: state IDLE, o_busy=0, o_grant=0, last_owner=1 (so master 0 wins first tie), o_timeout=0, counters=0. All driver-side valid/sop/eop outputs=0, all master ready/read_valid=0. Reset mid-transaction aborts immediately to IDLE.
- Driver-side data/address fields are a combinational mux of the granted master, and 0 when not busy. Valid strobes are gated by state.
- IDLE: if exactly one i_mN_operation_valid is high, grant N. If both are high, grant the master != last_owner. Register o_grant and set o_busy=1 next cycle, then go ISSUE (1-cycle arbitration latency). Masters see no ready while in IDLE.
- ISSUE:
  - o_ctrl_operation_valid = granted valid.
  - o_mG_operation_ready = i_ctrl_operation_ready. The other master's ready = 0.
  - On accept (valid&ready): latch type and len (len_q), clear byte counter and watchdog. Go WR if type==WR_TYPE, else RD.
  - If the granted master drops valid before accept: release, go IDLE, last_owner unchanged.
- WR:
  - Forward the granted write bus; non-granted write strobes are ignored.
  - On write_valid&eop forwarded: go RELEASE.
- RD:
  - Route i_ctrl_read_data/valid to the granted master only; the other master's read_valid stays 0.
  - Count beats (8-bit). When count reaches len_q, go RELEASE.
  - len_q==0: go RELEASE immediately.
  - Extra read beats arriving after RELEASE are dropped.
- RELEASE: wait for i_ctrl_operation_ready==1, then set last_owner=grant, o_busy=0, go IDLE. Back-to-back requests are re-arbitrated: minimum 2 idle cycles between driver ops.
- Watchdog:
  - 24-bit counter increments in WR/RD/RELEASE and saturates.
  - At TIMEOUT_CYC-1: pulse o_timeout, force strobes low, set last_owner=grant, go IDLE.
- Simultaneous: a request arriving in the same cycle as RELEASE→IDLE is seen in IDLE on the next cycle. There is no preemption.

Test Plan:
- M0 only, read addr 0x0010 len 4; driver returns AA,BB,CC,DD → o_m0_read_valid pulses 4 times with those bytes, o_m1_read_valid stays 0, o_busy falls after driver ready high.
- Both masters request in the same cycle from reset → M0 granted first; after M0 completes, M1 granted. Next tie → M0 again (alternation).
- M1 write len 3 (sop, 11, 22, eop 33) while M0 holds valid → driver sees exactly 3 write beats from M1; M0 ready stays 0 until M1 RELEASE completes.
- Read len 0 → RELEASE entered immediately after accept; no read_valid routed; grant released when driver ready high.
- TIMEOUT_CYC=100, driver never returns read data → o_timeout pulses at cycle 99 after accept, o_busy=0, the other master gets the next grant.
- Assert i_rst low mid-write burst → all driver strobes drop asynchronously; after release of reset, state is IDLE and M0 wins the first tie.

Source files
------------

// File: rtl/eeprom_arbiter.sv
// Round-robin arbiter that shares one EEPROM driver between two masters.
// The grant is held from operation accept through the data phase until the driver is idle again.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | no owner; arbitrate between pending operation requests
// S_ISSUE   | owner's operation presented to the driver, waiting for accept
// S_WR      | owner's write burst forwarded until the eop beat
// S_RD      | driver read beats routed to the owner until len bytes arrive
// S_RELEASE | wait for the driver to report idle, then drop the grant
module eeprom_arbiter #(
    parameter logic [23:0] TIMEOUT_CYC = 24'd5_000_000,
    parameter logic [1:0]  WR_TYPE     = 2'd1
) (
    input  logic        i_clk,
    input  logic        i_rst,

    input  logic [2:0]  i_m0_eeprom_addr,
    input  logic [15:0] i_m0_operation_addr,
    input  logic [1:0]  i_m0_operation_type,
    input  logic [7:0]  i_m0_operation_len,
    input  logic        i_m0_operation_valid,
    output logic        o_m0_operation_ready,
    input  logic [7:0]  i_m0_write_data,
    input  logic        i_m0_write_sop,
    input  logic        i_m0_write_eop,
    input  logic        i_m0_write_valid,
    output logic [7:0]  o_m0_read_data,
    output logic        o_m0_read_valid,

    input  logic [2:0]  i_m1_eeprom_addr,
    input  logic [15:0] i_m1_operation_addr,
    input  logic [1:0]  i_m1_operation_type,
    input  logic [7:0]  i_m1_operation_len,
    input  logic        i_m1_operation_valid,
    output logic        o_m1_operation_ready,
    input  logic [7:0]  i_m1_write_data,
    input  logic        i_m1_write_sop,
    input  logic        i_m1_write_eop,
    input  logic        i_m1_write_valid,
    output logic [7:0]  o_m1_read_data,
    output logic        o_m1_read_valid,

    output logic [2:0]  o_ctrl_eeprom_addr,
    output logic [15:0] o_ctrl_operation_addr,
    output logic [1:0]  o_ctrl_operation_type,
    output logic [7:0]  o_ctrl_operation_len,
    output logic        o_ctrl_operation_valid,
    input  logic        i_ctrl_operation_ready,
    output logic [7:0]  o_ctrl_write_data,
    output logic        o_ctrl_write_sop,
    output logic        o_ctrl_write_eop,
    output logic        o_ctrl_write_valid,
    input  logic [7:0]  i_ctrl_read_data,
    input  logic        i_ctrl_read_valid,

    output logic        o_grant,
    output logic        o_busy,
    output logic        o_timeout
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WR      = 3'd2;
    localparam logic [2:0] S_RD      = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    logic [2:0]  state;
    logic        grant;
    logic        busy;
    logic        last_owner;
    logic        timeout_q;
    logic [7:0]  len_q;
    logic [7:0]  beat_cnt;
    logic [23:0] wdog;

    logic [2:0]  g_eeprom_addr;
    logic [15:0] g_op_addr;
    logic [1:0]  g_op_type;
    logic [7:0]  g_op_len;
    logic        g_op_valid;
    logic [7:0]  g_wr_data;
    logic        g_wr_sop;
    logic        g_wr_eop;
    logic        g_wr_valid;

    logic        wd_active;
    logic        wd_hit;
    logic        wr_fwd;
    logic        rd_fwd;

    always_comb begin
        if (grant) begin
            g_eeprom_addr = i_m1_eeprom_addr;
            g_op_addr     = i_m1_operation_addr;
            g_op_type     = i_m1_operation_type;
            g_op_len      = i_m1_operation_len;
            g_op_valid    = i_m1_operation_valid;
            g_wr_data     = i_m1_write_data;
            g_wr_sop      = i_m1_write_sop;
            g_wr_eop      = i_m1_write_eop;
            g_wr_valid    = i_m1_write_valid;
        end else begin
            g_eeprom_addr = i_m0_eeprom_addr;
            g_op_addr     = i_m0_operation_addr;
            g_op_type     = i_m0_operation_type;
            g_op_len      = i_m0_operation_len;
            g_op_valid    = i_m0_operation_valid;
            g_wr_data     = i_m0_write_data;
            g_wr_sop      = i_m0_write_sop;
            g_wr_eop      = i_m0_write_eop;
            g_wr_valid    = i_m0_write_valid;
        end
    end

    // The watchdog hit cycle already suppresses all forwarded strobes.
    assign wd_active = (state == S_WR) || (state == S_RD) || (state == S_RELEASE);
    assign wd_hit    = wd_active && (wdog == TIMEOUT_CYC - 24'd1);
    assign wr_fwd    = (state == S_WR) && !wd_hit;
    assign rd_fwd    = (state == S_RD) && !wd_hit;

    assign o_ctrl_eeprom_addr     = busy ? g_eeprom_addr : 3'd0;
    assign o_ctrl_operation_addr  = busy ? g_op_addr     : 16'd0;
    assign o_ctrl_operation_type  = busy ? g_op_type     : 2'd0;
    assign o_ctrl_operation_len   = busy ? g_op_len      : 8'd0;
    assign o_ctrl_write_data      = busy ? g_wr_data     : 8'd0;
    assign o_ctrl_operation_valid = (state == S_ISSUE) && g_op_valid;
    assign o_ctrl_write_valid     = wr_fwd && g_wr_valid;
    assign o_ctrl_write_sop       = wr_fwd && g_wr_valid && g_wr_sop;
    assign o_ctrl_write_eop       = wr_fwd && g_wr_valid && g_wr_eop;

    assign o_m0_operation_ready = (state == S_ISSUE) && !grant && i_ctrl_operation_ready;
    assign o_m1_operation_ready = (state == S_ISSUE) &&  grant && i_ctrl_operation_ready;

    assign o_m0_read_valid = rd_fwd && !grant && i_ctrl_read_valid;
    assign o_m1_read_valid = rd_fwd &&  grant && i_ctrl_read_valid;
    assign o_m0_read_data  = (rd_fwd && !grant) ? i_ctrl_read_data : 8'd0;
    assign o_m1_read_data  = (rd_fwd &&  grant) ? i_ctrl_read_data : 8'd0;

    assign o_grant   = grant;
    assign o_busy    = busy;
    assign o_timeout = timeout_q;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state      <= S_IDLE;
            grant      <= 1'b0;
            busy       <= 1'b0;
            last_owner <= 1'b1;
            timeout_q  <= 1'b0;
            len_q      <= 8'd0;
            beat_cnt   <= 8'd0;
            wdog       <= 24'd0;
        end else begin
            timeout_q <= 1'b0;
            if (wd_active && (wdog != 24'hFF_FFFF)) begin
                wdog <= wdog + 24'd1;
            end

            if (wd_hit) begin
                timeout_q  <= 1'b1;
                last_owner <= grant;
                busy       <= 1'b0;
                state      <= S_IDLE;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (i_m0_operation_valid || i_m1_operation_valid) begin
                            if (i_m0_operation_valid && i_m1_operation_valid) begin
                                grant <= !last_owner;
                            end else begin
                                grant <= i_m1_operation_valid;
                            end
                            busy  <= 1'b1;
                            state <= S_ISSUE;
                        end
                    end
                    S_ISSUE: begin
                        if (!g_op_valid) begin
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else if (i_ctrl_operation_ready) begin
                            len_q    <= g_op_len;
                            beat_cnt <= 8'd0;
                            wdog     <= 24'd0;
                            if (g_op_type == WR_TYPE) begin
                                state <= S_WR;
                            end else if (g_op_len == 8'd0) begin
                                state <= S_RELEASE;
                            end else begin
                                state <= S_RD;
                            end
                        end
                    end
                    S_WR: begin
                        if (g_wr_valid && g_wr_eop) begin
                            state <= S_RELEASE;
                        end
                    end
                    S_RD: begin
                        if (i_ctrl_read_valid) begin
                            beat_cnt <= beat_cnt + 8'd1;
                            if (beat_cnt + 8'd1 == len_q) begin
                                state <= S_RELEASE;
                            end
                        end
                    end
                    S_RELEASE: begin
                        if (i_ctrl_operation_ready) begin
                            last_owner <= grant;
                            busy       <= 1'b0;
                            state      <= S_IDLE;
                        end
                    end
                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
